// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller wrapped around an external PC register.
// It computes the PC register's next value, runs the instruction-memory req/ack
// handshake and holds one fetched instruction for decode. A redirect from execute
// squashes both the buffered instruction and any fetch that is still in flight.
//
// Handshakes:
//   imem: imem_req/imem_addr are held until imem_ack. A request is never withdrawn
//         once issued, and imem_ack may arrive in the same cycle as the request.
//   decode: a transfer happens when id_valid && id_ready. id_* stay stable while
//         id_valid && !id_ready. In a redirect cycle the buffer is flushed and no
//         transfer takes place.
module fetch_ctrl #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(32'hBFC00000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_q,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [WIDTH-1:0] id_pc,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] load_pc;
  logic             buf_free;
  logic             redir;
  logic             load;

  assign buf_free  = !id_valid || id_ready;
  assign redir     = redirect_valid && (state != BOOT);
  assign pc_inc    = pc_q + WIDTH'(4);
  assign dbg_state = state;

  // Next-state, request and next-PC decode; a redirect overrides ack and advance.
  always_comb begin
    state_d   = state;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    pc_next   = pc_q;
    load      = 1'b0;
    load_pc   = pc_q;
    case (state)
      BOOT: begin
        pc_next = RESET_PC;
        state_d = RUN;
      end
      RUN: begin
        imem_req  = buf_free && !redirect_valid;
        imem_addr = pc_q;
        if (imem_req && imem_ack) begin
          load    = 1'b1;
          load_pc = pc_q;
          pc_next = pc_inc;
        end else if (imem_req) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
        if (imem_ack) begin
          load    = 1'b1;
          load_pc = req_addr;
          pc_next = pc_inc;
          state_d = RUN;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
        if (imem_ack) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
    if (redir) begin
      pc_next = redirect_pc;
      load    = 1'b0;
      // An outstanding request that is not acked now must still be drained.
      if (state != RUN) state_d = imem_ack ? RUN : DRAIN;
    end
  end

  // FSM state and outstanding-request address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= BOOT;
      req_addr <= '0;
    end else begin
      state <= state_d;
      if (state == RUN && imem_req) req_addr <= pc_q;
    end
  end

  // Decode-side instruction buffer: flush on redirect, load on ack, empty on consume.
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else if (redir) begin
      id_valid <= 1'b0;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc    <= load_pc;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule
